// File: rtl/nvram_access_arbiter.sv
// Two-port arbiter for the NVRAM behind the SequenceGenerator, round-robin on contention.
// Latency: Req sampled at edge 0 -> StartCycle for CYCLE_CLKS clocks (+Hold) -> one-clock Ack.
// Backpressure: requesters hold Req until Ack; Hold stretches the active cycle.
module nvram_access_arbiter #(
    parameter int          ADDR_WIDTH   = 15,
    parameter int          CYCLE_CLKS   = 4,
    parameter int          RECOVER_CLKS = 1,
    parameter logic [2:0]  SEQ_DELAY    = 3'b011
) (
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  ReqA,
    input  logic                  WriteA,
    input  logic [ADDR_WIDTH-1:0] AddrA,
    input  logic [7:0]            WDataA,
    input  logic                  HoldA,
    output logic                  AckA,
    output logic [7:0]            RDataA,
    input  logic                  ReqB,
    input  logic                  WriteB,
    input  logic [ADDR_WIDTH-1:0] AddrB,
    input  logic [7:0]            WDataB,
    input  logic                  HoldB,
    output logic                  AckB,
    output logic [7:0]            RDataB,
    output logic                  StartCycle,
    output logic                  ReadSeq,
    output logic                  WriteSeq,
    output logic                  Extend,
    output logic [2:0]            Delay,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [7:0]            MemWData,
    output logic                  DataOE,
    input  logic [7:0]            MemRData,
    output logic [1:0]            Grant,
    output logic                  Busy
);

    localparam int CNT_MAX = (CYCLE_CLKS > RECOVER_CLKS) ? CYCLE_CLKS : RECOVER_CLKS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CYC_LOAD = CW'(CYCLE_CLKS - 1);
    localparam logic [CW-1:0] REC_LOAD = CW'((RECOVER_CLKS > 0) ? RECOVER_CLKS - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE,
        ST_RECOVER
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    dir_q, dir_d;
    logic [1:0]              gnt_q, gnt_d;
    logic                    last_b_q, last_b_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              wdat_q, wdat_d;
    logic [7:0]              rdat_a_q, rdat_a_d;
    logic [7:0]              rdat_b_q, rdat_b_d;
    logic                    start_q, start_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic                    oe_q, oe_d;
    logic                    busy_q, busy_d;
    logic                    ack_a_q, ack_a_d;
    logic                    ack_b_q, ack_b_d;
    logic                    hold_sel;
    logic                    pick_b;

    assign hold_sel = gnt_q[1] ? HoldB : HoldA;
    // B wins when alone, or on contention when A had the last grant
    assign pick_b   = ReqB && (!ReqA || !last_b_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        gnt_d    = gnt_q;
        last_b_d = last_b_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rdat_a_d = rdat_a_q;
        rdat_b_d = rdat_b_q;

        case (state_q)
            ST_IDLE: begin
                if (ReqA || ReqB) begin
                    gnt_d    = pick_b ? 2'b10 : 2'b01;
                    last_b_d = pick_b;
                    addr_d   = pick_b ? AddrB  : AddrA;
                    wdat_d   = pick_b ? WDataB : WDataA;
                    dir_d    = pick_b ? WriteB : WriteA;
                    cnt_d    = CYC_LOAD;
                    state_d  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!hold_sel) begin
                    if (cnt_q == '0) begin
                        if (!dir_q) begin
                            if (gnt_q[1]) rdat_b_d = MemRData;
                            else          rdat_a_d = MemRData;
                        end
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (RECOVER_CLKS == 0) begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = REC_LOAD;
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == '0) begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so they leave the flops glitch-free
        start_d = (state_d == ST_ACTIVE);
        rd_d    = start_d && !dir_d;
        wr_d    = start_d && dir_d;
        oe_d    = start_d && dir_d;
        busy_d  = (state_d != ST_IDLE);
        ack_a_d = (state_d == ST_DONE) && gnt_d[0];
        ack_b_d = (state_d == ST_DONE) && gnt_d[1];
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            gnt_q    <= 2'b00;
            last_b_q <= 1'b1;
            addr_q   <= '0;
            wdat_q   <= '0;
            rdat_a_q <= '0;
            rdat_b_q <= '0;
            start_q  <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            gnt_q    <= gnt_d;
            last_b_q <= last_b_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rdat_a_q <= rdat_a_d;
            rdat_b_q <= rdat_b_d;
            start_q  <= start_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
        end
    end

    assign Extend     = (state_q == ST_ACTIVE) && hold_sel;
    assign Delay      = SEQ_DELAY;
    assign StartCycle = start_q;
    assign ReadSeq    = rd_q;
    assign WriteSeq   = wr_q;
    assign DataOE     = oe_q;
    assign Busy       = busy_q;
    assign Grant      = gnt_q;
    assign AckA       = ack_a_q;
    assign AckB       = ack_b_q;
    assign RDataA     = rdat_a_q;
    assign RDataB     = rdat_b_q;
    assign MemAddr    = addr_q;
    assign MemWData   = wdat_q;

endmodule
